// File: rtl/rvfi_gen_pkg.sv
// Shared types and constants for the synthetic RVFI register-trace generator.
//   REG_IDX_W  : architectural register index width
//   ORDER_W    : rvfi_order width
//   WDATA_W    : storage width of a command's write data (largest legal XLEN);
//                narrower builds use the low XLEN bits
//   reg_cmd_t  : one abstract register-op command (rs1, rs2, rd, wdata)
package rvfi_gen_pkg;

   localparam int REG_IDX_W = 5;
   localparam int ORDER_W   = 64;
   localparam int WDATA_W   = 64;

   typedef struct packed {
      logic [REG_IDX_W-1:0] rs1;
      logic [REG_IDX_W-1:0] rs2;
      logic [REG_IDX_W-1:0] rd;
      logic [WDATA_W-1:0]   wdata;
   } reg_cmd_t;

endpackage

// File: rtl/rvfi_gen_fifo.sv
// Synchronous command FIFO holding reg_cmd_t entries, with a multi-entry pop
// and a peek window of the NRET oldest entries.
// Ports:
//   clock, reset   : clock, synchronous active-high reset (empties the FIFO)
//   push/push_data : write one entry (caller guarantees !full)
//   pop_n          : number of entries to drop this cycle (caller guarantees <= count)
//   count, full    : occupancy
//   peek[i]        : i-th oldest entry (only meaningful for i < count)
module rvfi_gen_fifo
   import rvfi_gen_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int NRET  = 1,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1,
   localparam int NW    = $clog2(NRET + 1)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  reg_cmd_t               push_data,
   input  logic [NW-1:0]          pop_n,
   output logic [CNT_W-1:0]       count,
   output logic                   full,
   output reg_cmd_t [NRET-1:0]    peek
);

   reg_cmd_t         mem_q [DEPTH];
   reg_cmd_t         mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = push_data;
      // Pointers are exactly PTR_W bits, so wrap modulo DEPTH is implicit.
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_n);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop_n);
   end

   always_comb begin
      for (int i = 0; i < NRET; i++) begin
         peek[i] = mem_q[rd_ptr_q + PTR_W'(i)];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only observed below count.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

   assign count = count_q;
   assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/rvfi_reg_trace_gen.sv
// Synthetic RVFI producer: abstract register-op commands are buffered and
// retired (up to NRET per cycle) as RVFI packets whose rs1/rs2 read data come
// from an internal shadow register file, so the stream is register-consistent.
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   cmd_*                   : command handshake and fields (valid/ready)
//   retire_en               : allow retirement this cycle
//   rvfi_*                  : registered RVFI packet, NRET channels, channel 0 oldest
//   fault_inject            : only when RVFI_REG_TRACE_FAULT_EN is defined; flips
//                             bit 0 of channel 0 rs1_rdata in a retiring cycle
module rvfi_reg_trace_gen
   import rvfi_gen_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int NRET       = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                      clock,
   input  logic                      reset,
`ifdef RVFI_REG_TRACE_FAULT_EN
   input  logic                      fault_inject,
`endif
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [4:0]                cmd_rs1,
   input  logic [4:0]                cmd_rs2,
   input  logic [4:0]                cmd_rd,
   input  logic [XLEN-1:0]           cmd_wdata,
   input  logic                      retire_en,
   output logic [NRET-1:0]           rvfi_valid,
   output logic [NRET*64-1:0]        rvfi_order,
   output logic [NRET*5-1:0]         rvfi_rs1_addr,
   output logic [NRET*5-1:0]         rvfi_rs2_addr,
   output logic [NRET*5-1:0]         rvfi_rd_addr,
   output logic [NRET*XLEN-1:0]      rvfi_rs1_rdata,
   output logic [NRET*XLEN-1:0]      rvfi_rs2_rdata,
   output logic [NRET*XLEN-1:0]      rvfi_rd_wdata
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int NW    = $clog2(NRET + 1);

   reg_cmd_t             push_cmd;
   reg_cmd_t [NRET-1:0]  peek;
   logic [CNT_W-1:0]     count;
   logic                 full;
   logic                 push;
   logic [NW-1:0]        n;

   logic [XLEN-1:0]      regs_q [32];
   logic [XLEN-1:0]      regs_d [32];
   logic [ORDER_W-1:0]   order_base_q, order_base_d;

   logic [NRET-1:0]                 valid_q, valid_d;
   logic [NRET-1:0][ORDER_W-1:0]    order_q, order_d;
   logic [NRET-1:0][REG_IDX_W-1:0]  rs1_addr_q, rs1_addr_d;
   logic [NRET-1:0][REG_IDX_W-1:0]  rs2_addr_q, rs2_addr_d;
   logic [NRET-1:0][REG_IDX_W-1:0]  rd_addr_q, rd_addr_d;
   logic [NRET-1:0][XLEN-1:0]       rs1_rdata_q, rs1_rdata_d;
   logic [NRET-1:0][XLEN-1:0]       rs2_rdata_q, rs2_rdata_d;
   logic [NRET-1:0][XLEN-1:0]       rd_wdata_q, rd_wdata_d;

   // Held off during reset so a command offered then is never silently lost.
   assign cmd_ready = !full && !reset;
   assign push      = cmd_valid && cmd_ready;

   always_comb begin
      push_cmd                = '0;
      push_cmd.rs1            = cmd_rs1;
      push_cmd.rs2            = cmd_rs2;
      push_cmd.rd             = cmd_rd;
      push_cmd.wdata[XLEN-1:0] = cmd_wdata;
   end

   always_comb begin
      n = '0;
      if (retire_en) begin
         if (32'(count) >= NRET) n = NW'(NRET);
         else                    n = NW'(count);
      end
   end

   rvfi_gen_fifo #(
      .DEPTH (FIFO_DEPTH),
      .NRET  (NRET)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (push_cmd),
      .pop_n     (n),
      .count     (count),
      .full      (full),
      .peek      (peek)
   );

   // Channels are walked oldest first against a running copy of the shadow
   // file: a read sees the writes of all lower channels (highest one last),
   // and a channel's own write lands only after its reads.
   always_comb begin
      reg_cmd_t        c;
      logic [XLEN-1:0] wd;
      c            = '0;
      wd           = '0;
      regs_d       = regs_q;
      order_base_d = order_base_q + ORDER_W'(n);
      valid_d      = '0;
      order_d      = '0;
      rs1_addr_d   = '0;
      rs2_addr_d   = '0;
      rd_addr_d    = '0;
      rs1_rdata_d  = '0;
      rs2_rdata_d  = '0;
      rd_wdata_d   = '0;
      for (int i = 0; i < NRET; i++) begin
         if (i < int'(n)) begin
            c              = peek[i];
            wd             = c.wdata[XLEN-1:0];
            valid_d[i]     = 1'b1;
            order_d[i]     = order_base_q + ORDER_W'(i);
            rs1_addr_d[i]  = c.rs1;
            rs2_addr_d[i]  = c.rs2;
            rd_addr_d[i]   = c.rd;
            rs1_rdata_d[i] = (c.rs1 == '0) ? '0 : regs_d[c.rs1];
            rs2_rdata_d[i] = (c.rs2 == '0) ? '0 : regs_d[c.rs2];
            if (c.rd != '0) begin
               rd_wdata_d[i]  = wd;
               regs_d[c.rd]   = wd;
            end
         end
      end
`ifdef RVFI_REG_TRACE_FAULT_EN
      if (fault_inject && (n != '0)) rs1_rdata_d[0][0] = ~rs1_rdata_d[0][0];
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int r = 0; r < 32; r++) regs_q[r] <= '0;
         order_base_q <= '0;
         valid_q      <= '0;
         order_q      <= '0;
         rs1_addr_q   <= '0;
         rs2_addr_q   <= '0;
         rd_addr_q    <= '0;
         rs1_rdata_q  <= '0;
         rs2_rdata_q  <= '0;
         rd_wdata_q   <= '0;
      end else begin
         regs_q       <= regs_d;
         order_base_q <= order_base_d;
         valid_q      <= valid_d;
         order_q      <= order_d;
         rs1_addr_q   <= rs1_addr_d;
         rs2_addr_q   <= rs2_addr_d;
         rd_addr_q    <= rd_addr_d;
         rs1_rdata_q  <= rs1_rdata_d;
         rs2_rdata_q  <= rs2_rdata_d;
         rd_wdata_q   <= rd_wdata_d;
      end
   end

   // Upper wdata storage bits are dead when XLEN is narrower than WDATA_W.
   logic unused_peek;
   assign unused_peek = ^peek;

   assign rvfi_valid     = valid_q;
   assign rvfi_order     = order_q;
   assign rvfi_rs1_addr  = rs1_addr_q;
   assign rvfi_rs2_addr  = rs2_addr_q;
   assign rvfi_rd_addr   = rd_addr_q;
   assign rvfi_rs1_rdata = rs1_rdata_q;
   assign rvfi_rs2_rdata = rs2_rdata_q;
   assign rvfi_rd_wdata  = rd_wdata_q;

endmodule

// File: tb/tb_rvfi_reg_trace_gen.sv
// Bench for rvfi_reg_trace_gen (NRET=2, FIFO_DEPTH=4, XLEN=32). A queue-based
// reference model predicts every packet from the architectural rules: a read
// returns the value of the youngest older write to that register, else the
// committed shadow value. Directed steps first, then randomized traffic.
// Fault-path steps are compiled only with RVFI_REG_TRACE_FAULT_EN.
module tb_rvfi_reg_trace_gen;

   localparam int XLEN  = 32;
   localparam int NRET  = 2;
   localparam int DEPTH = 4;

   typedef struct {
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] wdata;
   } mcmd_t;

   logic                 clock;
   logic                 reset;
   logic                 fault_inject;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [4:0]           cmd_rs1, cmd_rs2, cmd_rd;
   logic [XLEN-1:0]      cmd_wdata;
   logic                 retire_en;
   logic [NRET-1:0]      rvfi_valid;
   logic [NRET*64-1:0]   rvfi_order;
   logic [NRET*5-1:0]    rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
   logic [NRET*XLEN-1:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;

   int checks   = 0;
   int failures = 0;

   mcmd_t           q[$];
   logic [XLEN-1:0] shadow [32];
   logic [63:0]     ord;

   logic [NRET-1:0]      ev;
   logic [NRET*64-1:0]   eo;
   logic [NRET*5-1:0]    ea1, ea2, ead;
   logic [NRET*XLEN-1:0] er1, er2, ewd;

   rvfi_reg_trace_gen #(.XLEN(XLEN), .NRET(NRET), .FIFO_DEPTH(DEPTH)) dut (
      .clock          (clock),
      .reset          (reset),
`ifdef RVFI_REG_TRACE_FAULT_EN
      .fault_inject   (fault_inject),
`endif
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_rs1        (cmd_rs1),
      .cmd_rs2        (cmd_rs2),
      .cmd_rd         (cmd_rd),
      .cmd_wdata      (cmd_wdata),
      .retire_en      (retire_en),
      .rvfi_valid     (rvfi_valid),
      .rvfi_order     (rvfi_order),
      .rvfi_rs1_addr  (rvfi_rs1_addr),
      .rvfi_rs2_addr  (rvfi_rs2_addr),
      .rvfi_rd_addr   (rvfi_rd_addr),
      .rvfi_rs1_rdata (rvfi_rs1_rdata),
      .rvfi_rs2_rdata (rvfi_rs2_rdata),
      .rvfi_rd_wdata  (rvfi_rd_wdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Value seen by channel ch reading register r: youngest older same-packet
   // write, else the committed shadow value.
   function automatic logic [XLEN-1:0] rd_val(input logic [4:0] r, input int ch);
      if (r == 5'd0) return '0;
      for (int k = ch - 1; k >= 0; k--) begin
         if (q[k].rd == r) return q[k].wdata;
      end
      return shadow[r];
   endfunction

   task automatic step(input bit rst, input bit vld, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] d, input logic [XLEN-1:0] wd, input bit ren, input bit fi);
      int    n;
      bit    acc;
      mcmd_t c;
      reset        = rst;
      cmd_valid    = vld;
      cmd_rs1      = a1;
      cmd_rs2      = a2;
      cmd_rd       = d;
      cmd_wdata    = wd;
      retire_en    = ren;
      fault_inject = fi;
      #1;
      chk("cmd_ready", 128'(cmd_ready), 128'(!rst && (q.size() < DEPTH)));
      ev = '0; eo = '0; ea1 = '0; ea2 = '0; ead = '0; er1 = '0; er2 = '0; ewd = '0;
      if (rst) begin
         q.delete();
         for (int r = 0; r < 32; r++) shadow[r] = '0;
         ord = '0;
      end else begin
         acc = vld && (q.size() < DEPTH);
         n   = ren ? ((q.size() < NRET) ? q.size() : NRET) : 0;
         for (int i = 0; i < n; i++) begin
            ev[i]               = 1'b1;
            eo[i*64 +: 64]      = ord + 64'(i);
            ea1[i*5 +: 5]       = q[i].rs1;
            ea2[i*5 +: 5]       = q[i].rs2;
            ead[i*5 +: 5]       = q[i].rd;
            er1[i*XLEN +: XLEN] = rd_val(q[i].rs1, i);
            er2[i*XLEN +: XLEN] = rd_val(q[i].rs2, i);
            ewd[i*XLEN +: XLEN] = (q[i].rd == 5'd0) ? '0 : q[i].wdata;
         end
`ifdef RVFI_REG_TRACE_FAULT_EN
         if (fi && n > 0) er1[0] = ~er1[0];
`endif
         for (int i = 0; i < n; i++) begin
            if (q[0].rd != 5'd0) shadow[q[0].rd] = q[0].wdata;
            void'(q.pop_front());
         end
         ord += 64'(n);
         if (acc) begin
            c.rs1 = a1; c.rs2 = a2; c.rd = d; c.wdata = wd;
            q.push_back(c);
         end
      end
      @(posedge clock);
      #1;
      chk("rvfi_valid", 128'(rvfi_valid), 128'(ev));
      chk("rvfi_order", 128'(rvfi_order), 128'(eo));
      chk("rvfi_rs1_addr", 128'(rvfi_rs1_addr), 128'(ea1));
      chk("rvfi_rs2_addr", 128'(rvfi_rs2_addr), 128'(ea2));
      chk("rvfi_rd_addr", 128'(rvfi_rd_addr), 128'(ead));
      chk("rvfi_rs1_rdata", 128'(rvfi_rs1_rdata), 128'(er1));
      chk("rvfi_rs2_rdata", 128'(rvfi_rs2_rdata), 128'(er2));
      chk("rvfi_rd_wdata", 128'(rvfi_rd_wdata), 128'(ewd));
   endtask

   task automatic idle(input bit ren);
      step(0, 0, 5'd0, 5'd0, 5'd0, '0, ren, 0);
   endtask

   task automatic push(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                       input logic [XLEN-1:0] wd, input bit ren);
      step(0, 1, a1, a2, d, wd, ren, 0);
   endtask

   initial begin
      logic [31:0] rnd;
      reset = 1'b1; cmd_valid = 1'b0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
      cmd_wdata = '0; retire_en = 1'b0; fault_inject = 1'b0;
      for (int r = 0; r < 32; r++) shadow[r] = '0;
      ord = '0;

      // Reset state
      step(1, 0, 5'd0, 5'd0, 5'd0, '0, 0, 0);
      step(1, 1, 5'd1, 5'd2, 5'd3, 32'h1, 1, 0);
      idle(1);

      // Basic write then dependent read
      push(5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF, 1);
      idle(1);
      chk("first_rd_wdata", 128'(rvfi_rd_wdata[31:0]), 128'(32'hDEAD_BEEF));
      chk("first_order", 128'(rvfi_order[63:0]), 128'(64'd0));
      push(5'd5, 5'd0, 5'd0, 32'd7, 1);
      idle(1);
      chk("x5_read", 128'(rvfi_rs1_rdata[31:0]), 128'(32'hDEAD_BEEF));
      chk("rd0_wdata", 128'(rvfi_rd_wdata[31:0]), 128'(32'd0));
      chk("second_order", 128'(rvfi_order[63:0]), 128'(64'd1));

      // Same-packet forwarding into channel 1, own-rd pre-write read
      push(5'd0, 5'd0, 5'd3, 32'd11, 0);
      push(5'd3, 5'd3, 5'd3, 32'd22, 0);
      idle(1);
      chk("fwd_rs1_ch1", 128'(rvfi_rs1_rdata[63:32]), 128'(32'd11));
      chk("fwd_rs2_ch1", 128'(rvfi_rs2_rdata[63:32]), 128'(32'd11));
      push(5'd3, 5'd0, 5'd0, 32'd0, 1);
      idle(1);
      chk("x3_after", 128'(rvfi_rs1_rdata[31:0]), 128'(32'd22));

      // Fill while stalled, then drain
      for (int i = 0; i < 5; i++) push(5'(i), 5'(i + 1), 5'(i + 8), 32'(100 + i), 0);
      chk("ready_full", 128'(cmd_ready), 128'(1'b0));
      idle(1);
      idle(1);
      idle(1);

      // Reset with buffered entries discards them and clears the shadow file
      push(5'd0, 5'd0, 5'd9, 32'd1, 0);
      push(5'd0, 5'd0, 5'd10, 32'd2, 0);
      push(5'd0, 5'd0, 5'd11, 32'd3, 0);
      step(1, 0, 5'd0, 5'd0, 5'd0, '0, 1, 0);
      idle(1);
      push(5'd5, 5'd3, 5'd0, 32'd0, 1);
      idle(1);
      chk("post_reset_x5", 128'(rvfi_rs1_rdata[31:0]), 128'(32'd0));
      chk("post_reset_order", 128'(rvfi_order[63:0]), 128'(64'd0));

      // Double write in one packet: highest channel wins
      push(5'd0, 5'd0, 5'd7, 32'd1, 0);
      push(5'd0, 5'd0, 5'd7, 32'd2, 0);
      idle(1);
      push(5'd7, 5'd0, 5'd0, 32'd0, 1);
      idle(1);
      chk("x7_last_wins", 128'(rvfi_rs1_rdata[31:0]), 128'(32'd2));

`ifdef RVFI_REG_TRACE_FAULT_EN
      push(5'd0, 5'd0, 5'd1, 32'd4, 1);
      idle(1);
      push(5'd1, 5'd0, 5'd0, 32'd0, 1);
      step(0, 0, 5'd0, 5'd0, 5'd0, '0, 1, 1);
      chk("fault_rs1", 128'(rvfi_rs1_rdata[31:0]), 128'(32'd5));
      push(5'd1, 5'd0, 5'd0, 32'd0, 1);
      idle(1);
      chk("unfaulted_rs1", 128'(rvfi_rs1_rdata[31:0]), 128'(32'd4));
`endif

      // Randomized traffic
      for (int s = 0; s < 400; s++) begin
         rnd = $urandom;
         step(rnd[6:0] == 7'd0,
              rnd[8:7] != 2'b00,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              $urandom,
              rnd[11:9] != 3'b000,
`ifdef RVFI_REG_TRACE_FAULT_EN
              rnd[15:12] == 4'd0
`else
              1'b0
`endif
              );
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
